wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_arbiter_hold_entry.sv | 63 ++++++
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: source encodings and
// default widths. Optional starvation guard macro: WB_STARVE_GUARD_EN.
package wb_arbiter_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_MAX_STALL = 3;

    // Source tag carried alongside each register-file write.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_hold_entry.sv
// Single-slot holding entry for one write-back source. It accepts a new
// result whenever it is empty or is being drained in the same cycle.
// Flush and reset both drop the slot and block the handshake.
module wb_hold_entry #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              pending,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] data
);

    logic              pending_d, pending_q;
    logic [ADDR_W-1:0] rd_d, rd_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              ready_c;
    logic              take_c;

    // Handshake and next-state of the slot; a refill wins over a drain.
    always_comb begin
        ready_c   = reset && !flush && (!pending_q || grant);
        take_c    = in_valid && ready_c;
        pending_d = pending_q;
        rd_d      = rd_q;
        data_d    = data_q;
        if (flush) begin
            pending_d = 1'b0;
        end else if (take_c) begin
            pending_d = 1'b1;
            rd_d      = in_rd;
            data_d    = in_data;
        end else if (grant) begin
            pending_d = 1'b0;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    assign in_ready = ready_c;
    assign pending  = pending_q;
    assign rd       = rd_q;
    assign data     = data_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and load data into one registered
// register-file write port. Memory normally wins; with WB_STARVE_GUARD_EN
// defined, an ALU entry that has lost MAX_STALL times in a row is forced
// through unless both target the same register (load-then-ALU order).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_STALL = DEF_MAX_STALL
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           alu_valid,
    output logic                           alu_ready,
    input  logic [ADDR_W-1:0]              alu_rd,
    input  logic [DATA_W-1:0]              alu_data,
    input  logic                           mem_valid,
    output logic                           mem_ready,
    input  logic [ADDR_W-1:0]              mem_rd,
    input  logic [DATA_W-1:0]              mem_data,
    output logic                           rf_we,
    output logic [ADDR_W-1:0]              rf_waddr,
    output logic [DATA_W-1:0]              rf_wdata,
    output logic                           wb_src,
    output logic [$clog2(MAX_STALL+1)-1:0] stall_cnt
);

    localparam int                 STALL_W   = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

    logic              alu_pend, mem_pend;
    logic [ADDR_W-1:0] alu_rd_h, mem_rd_h;
    logic [DATA_W-1:0] alu_data_h, mem_data_h;
    logic              alu_grant, mem_grant;
    logic              both_pend, guard_hit;

    logic               rf_we_d, rf_we_q;
    logic [ADDR_W-1:0]  rf_waddr_d, rf_waddr_q;
    logic [DATA_W-1:0]  rf_wdata_d, rf_wdata_q;
    wb_src_e            src_d, src_q;
    logic [STALL_W-1:0] stall_cnt_d, stall_cnt_q;

    wb_hold_entry #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_alu_entry (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_rd    (alu_rd),
        .in_data  (alu_data),
        .grant    (alu_grant),
        .pending  (alu_pend),
        .rd       (alu_rd_h),
        .data     (alu_data_h)
    );

    wb_hold_entry #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_entry (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (mem_valid),
        .in_ready (mem_ready),
        .in_rd    (mem_rd),
        .in_data  (mem_data),
        .grant    (mem_grant),
        .pending  (mem_pend),
        .rd       (mem_rd_h),
        .data     (mem_data_h)
    );

    // Grant selection from the held entries only; memory wins ties.
    always_comb begin
        both_pend = alu_pend && mem_pend;
`ifdef WB_STARVE_GUARD_EN
        // Same destination keeps memory first so the ALU value lands last.
        guard_hit = both_pend && (stall_cnt_q == STALL_MAX) && (alu_rd_h != mem_rd_h);
`else
        guard_hit = 1'b0;
`endif
        alu_grant = alu_pend && (!mem_pend || guard_hit);
        mem_grant = mem_pend && !alu_grant;
    end

    // Next write-port values and ALU-loss counter; flush suppresses any write.
    always_comb begin
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        src_d       = src_q;
        stall_cnt_d = '0;
        if (!flush) begin
            if (mem_grant) begin
                rf_we_d    = (mem_rd_h != '0);
                rf_waddr_d = mem_rd_h;
                rf_wdata_d = mem_data_h;
                src_d      = WB_SRC_MEM;
            end else if (alu_grant) begin
                rf_we_d    = (alu_rd_h != '0);
                rf_waddr_d = alu_rd_h;
                rf_wdata_d = alu_data_h;
                src_d      = WB_SRC_ALU;
            end
            if (both_pend && mem_grant) begin
                stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q
                                                         : stall_cnt_q + STALL_W'(1);
            end
        end
    end

    // Registered write port and counter with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            src_q       <= WB_SRC_ALU;
            stall_cnt_q <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            src_q       <= src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign wb_src    = src_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the arbitration rules.
module tb_wb_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int MS = 3;

    logic          clk = 1'b0;
    logic          reset, flush;
    logic          alu_valid, alu_ready, mem_valid, mem_ready;
    logic [AW-1:0] alu_rd, mem_rd, rf_waddr;
    logic [DW-1:0] alu_data, mem_data, rf_wdata;
    logic          rf_we, wb_src;
    logic [1:0]    stall_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit m_ap, m_mp, m_we, m_src;
    int m_ard, m_ad, m_mrd, m_md, m_stall, m_waddr, m_wdata;
    int rf_dut [8];

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_STALL(MS)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wb_src    (wb_src),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readies, advance model, check outputs.
    task automatic step(input bit rst, input bit fl, input bit av, input int ard, input int ad,
                        input bit mv, input int mrd, input int md);
        bit both, guard, g_a, g_m, ra, rm;
        reset     = rst;
        flush     = fl;
        alu_valid = av;
        alu_rd    = ard[AW-1:0];
        alu_data  = ad[DW-1:0];
        mem_valid = mv;
        mem_rd    = mrd[AW-1:0];
        mem_data  = md[DW-1:0];
        both  = m_ap && m_mp;
        guard = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        guard = both && (m_stall == MS) && (m_ard != m_mrd);
`endif
        g_a = m_ap && (!m_mp || guard);
        g_m = m_mp && !g_a;
        ra  = rst && !fl && (!m_ap || g_a);
        rm  = rst && !fl && (!m_mp || g_m);
        #1;
        chk("alu_ready", 32'(alu_ready), 32'(ra));
        chk("mem_ready", 32'(mem_ready), 32'(rm));
        if (!rst) begin
            m_ap = 0; m_mp = 0; m_we = 0; m_src = 0;
            m_stall = 0; m_waddr = 0; m_wdata = 0;
        end else if (fl) begin
            m_ap = 0; m_mp = 0; m_we = 0; m_stall = 0;
        end else begin
            m_we = 0;
            if (g_m) begin
                m_we = (m_mrd != 0); m_waddr = m_mrd; m_wdata = m_md; m_src = 1;
            end else if (g_a) begin
                m_we = (m_ard != 0); m_waddr = m_ard; m_wdata = m_ad; m_src = 0;
            end
            m_stall = (both && g_m) ? ((m_stall < MS) ? m_stall + 1 : MS) : 0;
            if (av && ra) begin m_ap = 1; m_ard = ard; m_ad = ad; end
            else if (g_a) m_ap = 0;
            if (mv && rm) begin m_mp = 1; m_mrd = mrd; m_md = md; end
            else if (g_m) m_mp = 0;
        end
        @(posedge clk);
        #1;
        if (rf_we === 1'b1) rf_dut[rf_waddr] = int'(rf_wdata);
        chk("rf_we",     32'(rf_we),     32'(m_we));
        chk("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
        chk("rf_wdata",  32'(rf_wdata),  32'(m_wdata));
        chk("wb_src",    32'(wb_src),    32'(m_src));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_we",    32'(rf_we),     32'd0);
        chk("rst_waddr", 32'(rf_waddr),  32'd0);
        chk("rst_wdata", 32'(rf_wdata),  32'd0);
        chk("rst_src",   32'(wb_src),    32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        idle();

        // ALU only: write appears two edges after the handshake
        step(1, 0, 1, 2, 'h5A, 0, 0, 0);
        chk("lat_early_we", 32'(rf_we), 32'd0);
        idle();
        chk("lat_we",    32'(rf_we),    32'd1);
        chk("lat_waddr", 32'(rf_waddr), 32'd2);
        chk("lat_wdata", 32'(rf_wdata), 32'h5A);
        chk("lat_src",   32'(wb_src),   32'd0);
        idle();

        // Simultaneous: memory first, ALU next
        step(1, 0, 1, 1, 'h11, 1, 3, 'h33);
        idle();
        chk("sim_mem_waddr", 32'(rf_waddr),  32'd3);
        chk("sim_mem_wdata", 32'(rf_wdata),  32'h33);
        chk("sim_mem_src",   32'(wb_src),    32'd1);
        chk("sim_stall1",    32'(stall_cnt), 32'd1);
        idle();
        chk("sim_alu_waddr", 32'(rf_waddr),  32'd1);
        chk("sim_alu_wdata", 32'(rf_wdata),  32'h11);
        chk("sim_alu_src",   32'(wb_src),    32'd0);
        chk("sim_stall0",    32'(stall_cnt), 32'd0);
        idle();

        // Memory continuously valid while ALU waits
        step(1, 0, 1, 5, 'hA5, 1, 6, 'h60);
        for (int i = 1; i <= 6; i++) begin
            step(1, 0, 0, 0, 0, 1, 6, 'h60 + i);
            chk("starve_we", 32'(rf_we), 32'd1);
`ifdef WB_STARVE_GUARD_EN
            chk("starve_src", 32'(wb_src), (i == 4) ? 32'd0 : 32'd1);
`else
            chk("starve_src", 32'(wb_src), 32'd1);
`endif
            if (i == 3) chk("starve_stall_sat", 32'(stall_cnt), 32'd3);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("starve_tail_src", 32'(wb_src), 32'd1);
        idle();
`ifdef WB_STARVE_GUARD_EN
        chk("starve_end_we", 32'(rf_we), 32'd0);
`else
        chk("starve_end_we",  32'(rf_we),    32'd1);
        chk("starve_end_src", 32'(wb_src),   32'd0);
        chk("starve_end_rd",  32'(rf_waddr), 32'd5);
`endif
        idle();

        // Same destination with saturated counter: memory first, ALU value lands last
        step(1, 0, 1, 4, 'hC4, 1, 4, 'h40);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 0, 0, 1, 4, 'h40 + i);
            chk("samerd_src", 32'(wb_src), 32'd1);
        end
        chk("samerd_stall", 32'(stall_cnt), 32'd3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("samerd_memlast", 32'(wb_src), 32'd1);
        idle();
        chk("samerd_alu_src", 32'(wb_src), 32'd0);
        chk("samerd_rf4", 32'(rf_dut[4]), 32'hC4);
        idle();

        // ALU writing rd 0: drains silently
        step(1, 0, 1, 0, 'h77, 0, 0, 0);
        idle();
        chk("rd0_we", 32'(rf_we), 32'd0);
        chk("rd0_ready", 32'(alu_ready), 32'd1);
        idle();

        // Flush with both pending
        step(1, 0, 1, 2, 'h22, 1, 5, 'h55);
        step(1, 1, 1, 3, 'h23, 1, 6, 'h56);
        chk("flush_we",    32'(rf_we),     32'd0);
        chk("flush_stall", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("flush_after_we", 32'(rf_we), 32'd0);
        end

        // Reset with both pending
        step(1, 0, 1, 6, 'h66, 1, 7, 'h77);
        step(0, 0, 1, 6, 'h66, 1, 7, 'h77);
        chk("rstp_we",    32'(rf_we),     32'd0);
        chk("rstp_waddr", 32'(rf_waddr),  32'd0);
        chk("rstp_wdata", 32'(rf_wdata),  32'd0);
        chk("rstp_src",   32'(wb_src),    32'd0);
        chk("rstp_stall", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("rstp_after_we", 32'(rf_we), 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
